plab5_mcore_mem_resp_assemble_queue: RTL and testbench

//  Consumes the packed response control message {type,opaque,len} plus the response data word.

---
 rtl/plab5_mcore_mem_resp_assemble_queue.sv | 101 ++++++++++
 tb/tb_plab5_mcore_mem_resp_assemble_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_resp_assemble_queue.sv
// Memory response assemble queue: joins {type,opaque,len} with length-masked data and buffers
// the assembled response, tagged with its security domain, in an N-entry FIFO.
module plab5_mcore_mem_resp_assemble_queue #(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_data_nbits   = 32,
    parameter int unsigned p_num_entries  = 2,
    localparam int unsigned LenNbits   = $clog2(p_data_nbits / 8),
    localparam int unsigned CmsgNbits  = 3 + p_opaque_nbits + LenNbits,
    localparam int unsigned MsgNbits   = CmsgNbits + p_data_nbits,
    localparam int unsigned PtrNbits   = $clog2(p_num_entries),
    localparam int unsigned CountNbits = $clog2(p_num_entries) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_domain,
    input  logic [CmsgNbits-1:0]  in_cmsg,
    input  logic [p_data_nbits-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic                  out_domain,
    output logic [MsgNbits-1:0]   out_msg,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [CountNbits-1:0] count
);

    localparam int unsigned NumBytes = p_data_nbits / 8;

    logic [MsgNbits-1:0]      msg_q [p_num_entries];
    logic [p_num_entries-1:0] dom_q;
    logic [p_num_entries-1:0] valid_q;
    logic [PtrNbits-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrNbits-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CountNbits-1:0]    count_q, count_d;

    logic                    enq, deq, head_live;
    logic [2:0]              in_type;
    logic [LenNbits-1:0]     in_len;
    logic [p_data_nbits-1:0] masked_data;

    assign in_type = in_cmsg[CmsgNbits-1 -: 3];
    assign in_len  = in_cmsg[LenNbits-1:0];

    // Reads and AMOs keep the low len bytes (len==0 means all); writes carry no data.
    always_comb begin
        int unsigned keep_bytes;
        masked_data = '0;
        keep_bytes  = (in_len == '0) ? NumBytes : 32'(in_len);
        if (!(in_type == 3'd1 || in_type == 3'd2)) begin
            for (int unsigned i = 0; i < NumBytes; i++) begin
                if (i < keep_bytes) masked_data[i*8 +: 8] = in_data[i*8 +: 8];
            end
        end
    end

    assign in_rdy  = (count_q != CountNbits'(p_num_entries));
    assign out_val = (count_q != '0);
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + PtrNbits'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PtrNbits'(1);
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CountNbits'(1);
            2'b01:   count_d = count_q - CountNbits'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            dom_q    <= '0;
            for (int unsigned i = 0; i < p_num_entries; i++) msg_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (deq) valid_q[rd_ptr_q] <= 1'b0;
            if (enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
                dom_q[wr_ptr_q]   <= in_domain;
                msg_q[wr_ptr_q]   <= {in_cmsg, masked_data};
            end
        end
    end

    // Empty queue shows all-zero output rather than whatever the head slot last held.
    assign head_live  = out_val && valid_q[rd_ptr_q];
    assign out_msg    = head_live ? msg_q[rd_ptr_q] : '0;
    assign out_domain = head_live ? dom_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_plab5_mcore_mem_resp_assemble_queue.sv
// Directed bench for the memory response assemble queue (o=8, d=32, N=2).
module tb_plab5_mcore_mem_resp_assemble_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_domain;
    logic [12:0] in_cmsg;
    logic [31:0] in_data;
    logic        in_val;
    logic        in_rdy;
    logic        out_domain;
    logic [44:0] out_msg;
    logic        out_val;
    logic        out_rdy;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    plab5_mcore_mem_resp_assemble_queue #(
        .p_opaque_nbits(8),
        .p_data_nbits  (32),
        .p_num_entries (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_domain (in_domain),
        .in_cmsg   (in_cmsg),
        .in_data   (in_data),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .out_domain(out_domain),
        .out_msg   (out_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [7:0] op, input logic [1:0] len,
                         input logic [31:0] data, input logic dom);
        in_val    = 1'b1;
        in_cmsg   = {t, op, len};
        in_data   = data;
        in_domain = dom;
    endtask

    task automatic test_reset();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %b exp 0", out_val); end
        checks++; if (out_msg !== 45'd0) begin errors++; $display("FAIL reset_out_msg got %h exp 0", out_msg); end
        checks++; if (out_domain !== 1'b0) begin errors++; $display("FAIL reset_out_domain got %b exp 0", out_domain); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    endtask

    task automatic test_single_read();
        logic [44:0] exp;
        exp = {3'd0, 8'h5a, 2'd2, 32'h0000beef};
        out_rdy = 1'b0;
        drive(3'd0, 8'h5a, 2'd2, 32'hdeadbeef, 1'b1);
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL read_no_bypass got %b exp 0", out_val); end
        step();
        in_val = 1'b0;
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL read_out_val got %b exp 1", out_val); end
        checks++; if (out_msg !== exp) begin errors++; $display("FAIL read_out_msg got %h exp %h", out_msg, exp); end
        checks++; if (out_domain !== 1'b1) begin errors++; $display("FAIL read_out_domain got %b exp 1", out_domain); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL read_count got %0d exp 1", count); end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL read_drain got %b exp 0", out_val); end
    endtask

    task automatic test_write_resp();
        logic [44:0] exp;
        exp = {3'd1, 8'h11, 2'd0, 32'h0};
        drive(3'd1, 8'h11, 2'd0, 32'hffffffff, 1'b0);
        step();
        in_val = 1'b0;
        checks++; if (out_msg !== exp) begin errors++; $display("FAIL write_out_msg got %h exp %h", out_msg, exp); end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL write_drain_val got %b exp 0", out_val); end
        checks++; if (out_msg !== 45'd0) begin errors++; $display("FAIL write_drain_msg got %h exp 0", out_msg); end
    endtask

    task automatic test_masking();
        logic [2:0]  types [6] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd7};
        logic [1:0]  lens  [6] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2};
        logic [31:0] exps  [6] = '{32'h00000078, 32'h00345678, 32'h12345678,
                                   32'h00000000, 32'h00000078, 32'h00005678};
        for (int i = 0; i < 6; i++) begin
            drive(types[i], 8'(i), lens[i], 32'h12345678, 1'b0);
            step();
            in_val = 1'b0;
            checks++;
            if (out_msg[31:0] !== exps[i]) begin
                errors++;
                $display("FAIL mask_%0d data got %h exp %h", i, out_msg[31:0], exps[i]);
            end
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
        end
    endtask

    task automatic test_fill_drain();
        out_rdy = 1'b0;
        drive(3'd0, 8'h01, 2'd0, 32'h1, 1'b0);
        step();
        drive(3'd0, 8'h02, 2'd0, 32'h2, 1'b1);
        step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy got %b exp 0", in_rdy); end
        drive(3'd0, 8'h03, 2'd0, 32'h3, 1'b0);
        step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_reject_count got %0d exp 2", count); end
        // Still offering the third message: no pass-through when full.
        out_rdy = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_no_passthru got %b exp 0", in_rdy); end
        checks++; if (out_msg[41:34] !== 8'h01) begin errors++; $display("FAIL drain0_opaque got %h exp 01", out_msg[41:34]); end
        checks++; if (out_domain !== 1'b0) begin errors++; $display("FAIL drain0_domain got %b exp 0", out_domain); end
        in_val = 1'b0;
        step();
        checks++; if (out_msg[41:34] !== 8'h02) begin errors++; $display("FAIL drain1_opaque got %h exp 02", out_msg[41:34]); end
        checks++; if (out_domain !== 1'b1) begin errors++; $display("FAIL drain1_domain got %b exp 1", out_domain); end
        step();
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_val); end
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'd0, 8'(i), 2'd0, 32'(i), 1'(i % 2));
            #1;
            if (i > 0) begin
                checks++;
                if (out_msg[41:34] !== 8'(i - 1)) begin
                    errors++; $display("FAIL stream_%0d opaque got %h exp %h", i, out_msg[41:34], 8'(i - 1));
                end
                checks++;
                if (count !== 2'd1) begin errors++; $display("FAIL stream_%0d count got %0d exp 1", i, count); end
            end
            step();
        end
        in_val = 1'b0;
        checks++; if (out_msg[41:34] !== 8'h07) begin errors++; $display("FAIL stream_last got %h exp 07", out_msg[41:34]); end
        checks++; if (out_domain !== 1'b1) begin errors++; $display("FAIL stream_last_dom got %b exp 1", out_domain); end
        step();
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL stream_empty got %b exp 0", out_val); end
    endtask

    task automatic test_async_reset();
        logic [44:0] exp;
        exp = {3'd0, 8'h77, 2'd1, 32'h000000cd};
        out_rdy = 1'b0;
        drive(3'd0, 8'h21, 2'd0, 32'h1, 1'b1);
        step();
        drive(3'd0, 8'h22, 2'd0, 32'h2, 1'b1);
        step();
        in_val = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL prereset_count got %0d exp 2", count); end
        #1 reset = 1'b0;
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL async_out_val got %b exp 0", out_val); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL async_count got %0d exp 0", count); end
        checks++; if (out_msg !== 45'd0) begin errors++; $display("FAIL async_out_msg got %h exp 0", out_msg); end
        step();
        reset = 1'b1;
        drive(3'd0, 8'h77, 2'd1, 32'h0000abcd, 1'b0);
        step();
        in_val = 1'b0;
        checks++; if (out_msg !== exp) begin errors++; $display("FAIL postreset_msg got %h exp %h", out_msg, exp); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL postreset_count got %0d exp 1", count); end
    endtask

    initial begin
        reset     = 1'b0;
        in_val    = 1'b0;
        in_cmsg   = '0;
        in_data   = '0;
        in_domain = 1'b0;
        out_rdy   = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        test_reset();
        test_single_read();
        test_write_resp();
        test_masking();
        test_fill_drain();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
